// File: rtl/univ_shift_reg_if.sv
// univ_shift_reg_if
// Bundles the data/control signals of the universal shift register.
//   master : drives en, mode, pi, sin_r, sin_l; observes po, so_r, so_l,
//            cnt, drained (and par when USR_PARITY_EN is defined).
//   slave  : the shift register itself.
// Optional feature macro: USR_PARITY_EN adds the registered parity bit par.
interface univ_shift_reg_if #(
  parameter int WIDTH = 4,
  parameter int CW    = $clog2(WIDTH + 1)
);
  logic             en;
  logic [2:0]       mode;
  logic [WIDTH-1:0] pi;
  logic             sin_r;
  logic             sin_l;
  logic [WIDTH-1:0] po;
  logic             so_r;
  logic             so_l;
  logic [CW-1:0]    cnt;
  logic             drained;
`ifdef USR_PARITY_EN
  logic             par;
`endif

  modport master (
    output en, mode, pi, sin_r, sin_l,
    input  po, so_r, so_l, cnt, drained
`ifdef USR_PARITY_EN
    , input par
`endif
  );

  modport slave (
    input  en, mode, pi, sin_r, sin_l,
    output po, so_r, so_l, cnt, drained
`ifdef USR_PARITY_EN
    , output par
`endif
  );
endinterface

// File: rtl/univ_shift_reg.sv
// univ_shift_reg
// Parametrised universal shift register: parallel load, hold, clear,
// shift right/left with serial fill, rotate right/left. A saturating
// counter reports how many parallel-loaded bits are still un-shifted, so
// the block works as PISO, SIPO or a plain PIPO stage.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : univ_shift_reg_if.slave
//           en      - clock enable (0 holds all state)
//           mode    - 000 hold, 001 load, 010 shr, 011 shl, 100 ror,
//                     101 rol, 110 clear, 111 reserved (hold)
//           pi      - parallel in
//           sin_r   - serial in at MSB on shift right
//           sin_l   - serial in at LSB on shift left
//           po      - registered contents
//           so_r    - po[0];      so_l - po[WIDTH-1]
//           cnt     - loaded bits not yet shifted out
//           drained - cnt == 0
//           par     - registered even parity of po (USR_PARITY_EN only)
// Optional feature macro: USR_PARITY_EN.
module univ_shift_reg #(
  parameter int WIDTH = 4,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input logic              clk,
  input logic              rst_n,
  univ_shift_reg_if.slave  bus
);

  typedef enum logic [2:0] {
    MODE_HOLD  = 3'b000,
    MODE_LOAD  = 3'b001,
    MODE_SHR   = 3'b010,
    MODE_SHL   = 3'b011,
    MODE_ROR   = 3'b100,
    MODE_ROL   = 3'b101,
    MODE_CLEAR = 3'b110,
    MODE_RSVD  = 3'b111
  } mode_e;

  logic [WIDTH-1:0] po_p1;
  logic [WIDTH-1:0] po_nxt;
  logic [CW-1:0]    cnt_p1;
  logic [CW-1:0]    cnt_nxt;

  // Counter never wraps: shifting past empty leaves it at zero.
  function automatic logic [CW-1:0] sat_dec(input logic [CW-1:0] c);
    return (c == '0) ? '0 : c - 1'b1;
  endfunction

  function automatic logic even_parity(input logic [WIDTH-1:0] d);
    return ^d;
  endfunction

  always_comb begin
    po_nxt  = po_p1;
    cnt_nxt = cnt_p1;
    if (bus.en) begin
      case (mode_e'(bus.mode))
        MODE_LOAD: begin
          po_nxt  = bus.pi;
          cnt_nxt = CW'(WIDTH);
        end
        MODE_SHR: begin
          po_nxt  = {bus.sin_r, po_p1[WIDTH-1:1]};
          cnt_nxt = sat_dec(cnt_p1);
        end
        MODE_SHL: begin
          po_nxt  = {po_p1[WIDTH-2:0], bus.sin_l};
          cnt_nxt = sat_dec(cnt_p1);
        end
        MODE_ROR:   po_nxt = {po_p1[0], po_p1[WIDTH-1:1]};
        MODE_ROL:   po_nxt = {po_p1[WIDTH-2:0], po_p1[WIDTH-1]};
        MODE_CLEAR: begin
          po_nxt  = '0;
          cnt_nxt = '0;
        end
        default: ;
      endcase
    end
  end

  // Stage p1: register boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      po_p1  <= '0;
      cnt_p1 <= '0;
    end else begin
      po_p1  <= po_nxt;
      cnt_p1 <= cnt_nxt;
    end
  end

  assign bus.po      = po_p1;
  assign bus.so_r    = po_p1[0];
  assign bus.so_l    = po_p1[WIDTH-1];
  assign bus.cnt     = cnt_p1;
  assign bus.drained = (cnt_p1 == '0);

`ifdef USR_PARITY_EN
  logic par_p1;

  // Parity of next-po is captured on the same edge as po itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_p1 <= 1'b0;
    else        par_p1 <= even_parity(po_nxt);
  end

  assign bus.par = par_p1;
`else
  logic unused_par;
  assign unused_par = even_parity(po_nxt);
`endif

endmodule
